// File: rtl/vector_shift_issue_ctrl_pkg.sv
// vector_shift_issue_ctrl_pkg: shared encodings for the vector shift issue controller
package vec_shift_pkg;
  localparam int DEFAULT_VLEN = 512;
  typedef enum logic [2:0] {SH_SLL = 3'd0, SH_SRL = 3'd1, SH_SRA = 3'd2} shift_op_e;
  typedef enum logic [1:0] {OPSEL_VV = 2'd0, OPSEL_VX = 2'd1, OPSEL_VI = 2'd2, OPSEL_RSV = 2'd3} opsel_e;
  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEW64 = 2'd3} sew_e;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_e;
  function automatic int vl_width(int vlen);
    return $clog2(vlen / 8) + 1;
  endfunction
endpackage

// File: rtl/vector_shift_issue_ctrl_if.sv
// vector_shift_issue_ctrl_if: issue, shift-unit and writeback signals of the shift controller
interface vector_shift_issue_ctrl_if #(parameter int VLEN = 512);
  localparam int VLW = $clog2(VLEN / 8) + 1;
  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        issue_opsel;
  logic [2:0]        issue_shift_op;
  logic [1:0]        issue_sew;
  logic [VLW-1:0]    issue_vl;
  logic              issue_vm;
  logic [VLEN/8-1:0] issue_v0_mask;
  logic [VLEN-1:0]   issue_vs1_data;
  logic [VLEN-1:0]   issue_vs2_data;
  logic [63:0]       issue_scalar;
  logic [VLEN-1:0]   issue_vd_old;
  logic [4:0]        issue_vd;
  logic [VLEN-1:0]   sh_dataA;
  logic [VLEN-1:0]   sh_dataB;
  logic [2:0]        sh_op;
  logic [1:0]        sh_sew;
  logic [VLEN-1:0]   sh_result;
  logic              sh_done;
  logic              wb_valid;
  logic              wb_ready;
  logic [VLEN-1:0]   wb_data;
  logic [4:0]        wb_vd;
  logic              busy;
  modport slave (
    input  issue_valid, issue_opsel, issue_shift_op, issue_sew, issue_vl, issue_vm,
           issue_v0_mask, issue_vs1_data, issue_vs2_data, issue_scalar, issue_vd_old,
           issue_vd, sh_result, sh_done, wb_ready,
    output issue_ready, sh_dataA, sh_dataB, sh_op, sh_sew, wb_valid, wb_data, wb_vd, busy
  );
  modport master (
    output issue_valid, issue_opsel, issue_shift_op, issue_sew, issue_vl, issue_vm,
           issue_v0_mask, issue_vs1_data, issue_vs2_data, issue_scalar, issue_vd_old,
           issue_vd, sh_result, sh_done, wb_ready,
    input  issue_ready, sh_dataA, sh_dataB, sh_op, sh_sew, wb_valid, wb_data, wb_vd, busy
  );
endinterface

// File: rtl/vector_shift_issue_ctrl_merge.sv
// vec_shift_elem_merge: per-byte select of shift result vs old vd by element activity
module vec_shift_elem_merge #(
  parameter int VLEN = 512,
  parameter int VLW  = $clog2(VLEN / 8) + 1
) (
  input  logic [VLEN-1:0]   result,
  input  logic [VLEN-1:0]   vd_old,
  input  logic [1:0]        sew,
  input  logic [VLW-1:0]    vl,
  input  logic              vm,
  input  logic [VLEN/8-1:0] v0,
  output logic [VLEN-1:0]   merged
);
  for (genvar i = 0; i < VLEN / 8; i++) begin : g_byte
    logic [VLW-1:0] e;
    assign e = VLW'(i >> sew);
    assign merged[8*i +: 8] = (e < vl && (vm || v0[e[VLW-2:0]])) ? result[8*i +: 8] : vd_old[8*i +: 8];
  end
endmodule

// File: rtl/vector_shift_issue_ctrl.sv
// vector_shift_issue_ctrl: sequences one shift instruction through the shift unit to writeback
module vector_shift_issue_ctrl
  import vec_shift_pkg::*;
#(
  parameter int VLEN = DEFAULT_VLEN
) (
  input logic clk,
  input logic reset_n,
  vector_shift_issue_ctrl_if.slave bus
);
  localparam int VLW = vl_width(VLEN);
  localparam int NB  = VLEN / 8;
  state_e          st;
  logic [VLEN-1:0] a_q, b_q, vd_old_q, wb_data_q, merged, a_prep;
  logic [2:0]      op_q;
  logic [1:0]      sew_q;
  logic [VLW-1:0]  vl_q, vl_max, vl_c;
  logic            vm_q, wb_valid_q, busy_q, ready_q, bcast;
  logic [NB-1:0]   v0_q;
  logic [4:0]      vd_q;
  logic [2:0]      lane_mask;
  logic [7:0]      amt_mask;
  assign bcast     = bus.issue_opsel == OPSEL_VX || bus.issue_opsel == OPSEL_VI;
  assign lane_mask = 3'((4'd1 << bus.issue_sew) - 4'd1);
  assign amt_mask  = {2'b0, 6'h3F >> (2'd3 - bus.issue_sew)};
  assign vl_max    = VLW'(NB) >> bus.issue_sew;
  assign vl_c      = bus.issue_vl > vl_max ? vl_max : bus.issue_vl;
  // Amount lives in the element's lowest byte; upper bytes of each amount are cleared.
  for (genvar i = 0; i < NB; i++) begin : g_prep
    logic [2:0] off;
    logic [7:0] src;
    assign off = 3'(i) & lane_mask;
    assign src = bcast ? bus.issue_scalar[8*off +: 8] : bus.issue_vs1_data[8*i +: 8];
    assign a_prep[8*i +: 8] = off == 3'd0 ? src & amt_mask : 8'h0;
  end
  vec_shift_elem_merge #(.VLEN(VLEN), .VLW(VLW)) u_merge (
    .result (bus.sh_result),
    .vd_old (vd_old_q),
    .sew    (sew_q),
    .vl     (vl_q),
    .vm     (vm_q),
    .v0     (v0_q),
    .merged (merged)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      sew_q      <= '0;
      vl_q       <= '0;
      vm_q       <= 1'b0;
      v0_q       <= '0;
      vd_old_q   <= '0;
      vd_q       <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (st)
        IDLE: if (bus.issue_valid) begin
          a_q        <= a_prep;
          b_q        <= bus.issue_vs2_data;
          op_q       <= bus.issue_shift_op;
          sew_q      <= bus.issue_sew;
          vl_q       <= vl_c;
          vm_q       <= bus.issue_vm;
          v0_q       <= bus.issue_v0_mask;
          vd_old_q   <= bus.issue_vd_old;
          vd_q       <= bus.issue_vd;
          wb_data_q  <= bus.issue_vd_old;
          wb_valid_q <= vl_c == '0;
          busy_q     <= 1'b1;
          ready_q    <= 1'b0;
          st         <= vl_c == '0 ? WB : EXEC;
        end
        EXEC: if (bus.sh_done) begin
          wb_data_q  <= merged;
          wb_valid_q <= 1'b1;
          st         <= WB;
        end
        WB: if (bus.wb_ready) begin
          wb_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign bus.issue_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.sh_dataA    = a_q;
  assign bus.sh_dataB    = b_q;
  assign bus.sh_op       = op_q;
  assign bus.sh_sew      = sew_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_vd       = vd_q;
endmodule
